arcade_input_ctrl: RTL and testbench

//  Input front end placed directly upstream of scramble_top.button_in.
//  - Merges PS/2 key events from hps_io with joystick_0|joystick_1.
//  - Applies orientation remap.
//  - Turns a start press into an auto-coin sequence: coin pulse, gap, start pulse.
//  - Drives the registered, active-low 8-bit button vector consumed by the core.

---
 rtl/arcade_input_pkg.sv | 50 +++++
 rtl/arcade_input_ctrl_seq.sv | 120 ++++++++++++
 rtl/arcade_input_ctrl.sv | 95 +++++++++
 tb/tb_arcade_input_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arcade_input_pkg.sv
// Shared constants for the arcade input front end: PS/2 scan codes,
// joystick bit positions and the coin/start sequencer states.
package arcade_input_pkg;

    localparam int PAD_W      = 7;
    localparam int JOY_R      = 0;
    localparam int JOY_L      = 1;
    localparam int JOY_D      = 2;
    localparam int JOY_U      = 3;
    localparam int JOY_FIRE   = 4;
    localparam int JOY_START1 = 5;
    localparam int JOY_START2 = 6;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    // Direction keys match on the low byte only, so arrows and keypad both work.
    localparam logic [7:0] PS2_UP    = 8'h75;
    localparam logic [7:0] PS2_DOWN  = 8'h72;
    localparam logic [7:0] PS2_LEFT  = 8'h6B;
    localparam logic [7:0] PS2_RIGHT = 8'h74;

    localparam logic [8:0] PS2_FIRE_A = 9'h029;
    localparam logic [8:0] PS2_FIRE_B = 9'h014;
    localparam logic [8:0] PS2_START1 = 9'h005;
    localparam logic [8:0] PS2_START2 = 9'h006;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_COIN,
        SEQ_GAP,
        SEQ_START,
        SEQ_HOLD
    } seq_state_t;

    // One-hot key latch selection, laid out like a joystick word.
    function automatic logic [PAD_W-1:0] ps2_key_mask(input logic [8:0] code);
        logic [PAD_W-1:0] mask;
        mask = '0;
        if (code[7:0] == PS2_UP)    mask[JOY_U] = 1'b1;
        if (code[7:0] == PS2_DOWN)  mask[JOY_D] = 1'b1;
        if (code[7:0] == PS2_LEFT)  mask[JOY_L] = 1'b1;
        if (code[7:0] == PS2_RIGHT) mask[JOY_R] = 1'b1;
        if (code == PS2_FIRE_A || code == PS2_FIRE_B) mask[JOY_FIRE] = 1'b1;
        if (code == PS2_START1) mask[JOY_START1] = 1'b1;
        if (code == PS2_START2) mask[JOY_START2] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/arcade_input_ctrl_seq.sv
// Auto-coin sequencer: a start press becomes coin pulse, gap, then start pulse,
// with the start held for as long as the player keeps the button down.
module coin_start_seq
    import arcade_input_pkg::*;
#(
    parameter int COIN_LEN  = 100000,
    parameter int GAP_LEN   = 100000,
    parameter int START_LEN = 100000,
    parameter int CNT_W     = 20
) (
    input  logic clk,
    input  logic reset_n,
    input  logic ce,
    input  logic st1,
    input  logic st2,
    output logic coin,
    output logic start1,
    output logic start2,
    output logic busy
);

    // A zero length behaves as a single tick.
    localparam logic [CNT_W-1:0] COIN_LOAD  = CNT_W'((COIN_LEN  == 0) ? 0 : COIN_LEN  - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((GAP_LEN   == 0) ? 0 : GAP_LEN   - 1);
    localparam logic [CNT_W-1:0] START_LOAD = CNT_W'((START_LEN == 0) ? 0 : START_LEN - 1);

    seq_state_t       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             sel_reg;
    logic [1:0]       st_prev_reg;
    logic             coin_reg;
    logic [1:0]       start_reg;
    logic             busy_reg;

    logic [1:0] st;
    logic [1:0] rise;
    logic       cnt_zero;

    assign st       = {st2, st1};
    assign rise     = st & ~st_prev_reg;
    assign cnt_zero = (cnt_reg == '0);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg   <= SEQ_IDLE;
            cnt_reg     <= '0;
            sel_reg     <= 1'b0;
            st_prev_reg <= 2'b00;
            coin_reg    <= 1'b0;
            start_reg   <= 2'b00;
            busy_reg    <= 1'b0;
        end else begin
            st_prev_reg <= st;
            case (state_reg)
                SEQ_IDLE: begin
                    if (|rise) begin
                        // start1 wins a same-cycle tie.
                        sel_reg   <= ~rise[0];
                        cnt_reg   <= COIN_LOAD;
                        state_reg <= SEQ_COIN;
                        coin_reg  <= 1'b1;
                        busy_reg  <= 1'b1;
                    end
                end
                SEQ_COIN: begin
                    if (ce) begin
                        if (cnt_zero) begin
                            cnt_reg   <= GAP_LOAD;
                            state_reg <= SEQ_GAP;
                            coin_reg  <= 1'b0;
                        end else begin
                            cnt_reg <= cnt_reg - CNT_W'(1);
                        end
                    end
                end
                SEQ_GAP: begin
                    if (ce) begin
                        if (cnt_zero) begin
                            cnt_reg   <= START_LOAD;
                            state_reg <= SEQ_START;
                            start_reg <= sel_reg ? 2'b10 : 2'b01;
                        end else begin
                            cnt_reg <= cnt_reg - CNT_W'(1);
                        end
                    end
                end
                SEQ_START: begin
                    if (ce) begin
                        if (cnt_zero) begin
                            state_reg <= SEQ_HOLD;
                        end else begin
                            cnt_reg <= cnt_reg - CNT_W'(1);
                        end
                    end
                end
                SEQ_HOLD: begin
                    if (st == 2'b00) begin
                        state_reg <= SEQ_IDLE;
                        start_reg <= 2'b00;
                        busy_reg  <= 1'b0;
                    end else begin
                        start_reg <= sel_reg ? {st[1], 1'b0} : {1'b0, st[0]};
                    end
                end
                default: begin
                    state_reg <= SEQ_IDLE;
                    coin_reg  <= 1'b0;
                    start_reg <= 2'b00;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign coin   = coin_reg;
    assign start1 = start_reg[0];
    assign start2 = start_reg[1];
    assign busy   = busy_reg;

endmodule

// File: rtl/arcade_input_ctrl.sv
// Arcade input front end: PS/2 key decode merged with two joysticks, orientation
// remap, and the auto-coin sequencer, producing the core's active-low button vector.
module arcade_input_ctrl
    import arcade_input_pkg::*;
#(
    parameter int COIN_LEN  = 100000,
    parameter int GAP_LEN   = 100000,
    parameter int START_LEN = 100000,
    parameter int CNT_W     = 20
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ce,
    input  logic [64:0] ps2_key,
    input  logic [15:0] joy0,
    input  logic [15:0] joy1,
    input  logic        rotate,
    output logic [7:0]  button_out,
    output logic        seq_busy
);

    logic             old_tog_reg;
    logic [PAD_W-1:0] key_reg;
    logic [PAD_W-1:0] key_next;
    logic [4:0]       pad_reg;
    logic [4:0]       pad_next;

    logic             ps2_event;
    logic             pressed;
    logic             extended;
    logic [8:0]       code;
    logic [PAD_W-1:0] key_mask;
    logic [PAD_W-1:0] src;
    logic             coin;
    logic             start1;
    logic             start2;
    logic             unused_joy_bits;

    always_comb begin
        ps2_event = (ps2_key[64] != old_tog_reg);
        pressed   = (ps2_key[15:8] != PS2_BREAK);
        extended  = pressed ? (ps2_key[15:8] == PS2_EXT) : (ps2_key[23:16] == PS2_EXT);
        // Words with anything above the prefix bytes are not plain key events.
        code      = (ps2_key[63:24] != '0) ? 9'd0 : {extended, ps2_key[7:0]};
        key_mask  = ps2_key_mask(code);
        key_next  = key_reg;
        if (ps2_event) begin
            key_next = pressed ? (key_reg | key_mask) : (key_reg & ~key_mask);
        end
    end

    assign src = key_reg | joy0[PAD_W-1:0] | joy1[PAD_W-1:0];
    assign unused_joy_bits = ^{joy0[15:PAD_W], joy1[15:PAD_W]};

    // pad layout: [0]up [1]down [2]left [3]right [4]fire
    always_comb begin
        pad_next[0] = rotate ? src[JOY_L] : src[JOY_U];
        pad_next[1] = rotate ? src[JOY_R] : src[JOY_D];
        pad_next[2] = rotate ? src[JOY_D] : src[JOY_L];
        pad_next[3] = rotate ? src[JOY_U] : src[JOY_R];
        pad_next[4] = src[JOY_FIRE];
    end

    always_ff @(posedge clk_sys) begin
        old_tog_reg <= ps2_key[64];
        if (!reset_n) begin
            key_reg <= '0;
            pad_reg <= '0;
        end else begin
            key_reg <= key_next;
            pad_reg <= pad_next;
        end
    end

    coin_start_seq #(
        .COIN_LEN  (COIN_LEN),
        .GAP_LEN   (GAP_LEN),
        .START_LEN (START_LEN),
        .CNT_W     (CNT_W)
    ) u_seq (
        .clk     (clk_sys),
        .reset_n (reset_n),
        .ce      (ce),
        .st1     (src[JOY_START1]),
        .st2     (src[JOY_START2]),
        .coin    (coin),
        .start1  (start1),
        .start2  (start2),
        .busy    (seq_busy)
    );

    // Every bit comes straight from a register: pad_reg here, coin/start in the sequencer.
    assign button_out = ~{start2, pad_reg[4], coin, start1, pad_reg[3:0]};

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Directed bench for arcade_input_ctrl with short sequencer lengths and ce every 6th clock.
module tb_arcade_input_ctrl;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ce = 1'b0;
    logic [64:0] ps2_key = '0;
    logic [15:0] joy0 = '0;
    logic [15:0] joy1 = '0;
    logic        rotate = 1'b0;
    logic [7:0]  button_out;
    logic        seq_busy;

    int checks = 0;
    int failures = 0;
    int ce_div = 0;

    arcade_input_ctrl #(
        .COIN_LEN  (4),
        .GAP_LEN   (2),
        .START_LEN (3),
        .CNT_W     (20)
    ) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .ce         (ce),
        .ps2_key    (ps2_key),
        .joy0       (joy0),
        .joy1       (joy1),
        .rotate     (rotate),
        .button_out (button_out),
        .seq_busy   (seq_busy)
    );

    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) begin
        ce_div = (ce_div == 5) ? 0 : ce_div + 1;
        ce = (ce_div == 5);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic send_ps2(input logic [7:0] b2, input logic [7:0] b1, input logic [7:0] b0,
                            input logic [39:0] hi);
        ps2_key = {~ps2_key[64], hi, b2, b1, b0};
    endtask

    // Steps n clocks tracking coin/gap/start phases; counts ce edges whose preceding state was in each phase.
    task automatic observe(input int n, input bit release_on_coin, input bit st2_in_gap,
                           output int coin_ce, output int gap_ce, output int start_ce,
                           output int st2_low, output int first_coin);
        bit prev5, prev4, prevgap, coin_seen, start_seen, injected, b5, b4, gap_now;
        prev5 = 0; prev4 = 0; prevgap = 0; coin_seen = 0; start_seen = 0; injected = 0;
        coin_ce = 0; gap_ce = 0; start_ce = 0; st2_low = 0; first_coin = -1;
        for (int i = 0; i < n; i++) begin
            tick(1);
            if (ce) begin
                if (prev5)   coin_ce++;
                if (prevgap) gap_ce++;
                if (prev4)   start_ce++;
            end
            b5 = !button_out[5];
            b4 = !button_out[4];
            if (!button_out[7]) st2_low++;
            if (b5 && !coin_seen) begin
                coin_seen = 1;
                first_coin = i;
                if (release_on_coin) joy0 = 16'h0000;
            end
            if (b4) start_seen = 1;
            gap_now = coin_seen && !b5 && !start_seen;
            if (gap_now && st2_in_gap && !injected) begin
                joy0 = 16'h0040;
                injected = 1;
            end
            prev5 = b5;
            prev4 = b4;
            prevgap = gap_now;
        end
    endtask

    task automatic test_reset;
        ps2_key = {1'b1, 40'd0, 8'h00, 8'hE0, 8'h75};
        reset_n = 1'b0;
        tick(3);
        checks++; if (button_out !== 8'hFF) begin failures++; $display("FAIL reset_out: got %h expected ff", button_out); end
        checks++; if (seq_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", seq_busy); end
        reset_n = 1'b1;
        tick(3);
        checks++; if (button_out !== 8'hFF) begin failures++; $display("FAIL reset_no_event: got %h expected ff", button_out); end
        checks++; if (seq_busy !== 1'b0) begin failures++; $display("FAIL reset_release_busy: got %b expected 0", seq_busy); end
        $display("test_reset done: button_out=%h seq_busy=%b", button_out, seq_busy);
    endtask

    task automatic test_ps2;
        send_ps2(8'h00, 8'hE0, 8'h75, 40'd0);
        tick(1);
        checks++; if (button_out !== 8'hFF) begin failures++; $display("FAIL ps2_make_1clk: got %h expected ff", button_out); end
        tick(1);
        checks++; if (button_out !== 8'hFE) begin failures++; $display("FAIL ps2_make_2clk: got %h expected fe", button_out); end
        send_ps2(8'h00, 8'hF0, 8'h75, 40'd1);
        tick(3);
        checks++; if (button_out !== 8'hFE) begin failures++; $display("FAIL ps2_break_upper_nonzero: got %h expected fe", button_out); end
        send_ps2(8'hE0, 8'hF0, 8'h75, 40'd0);
        tick(1);
        checks++; if (button_out !== 8'hFE) begin failures++; $display("FAIL ps2_break_1clk: got %h expected fe", button_out); end
        tick(1);
        checks++; if (button_out !== 8'hFF) begin failures++; $display("FAIL ps2_break_2clk: got %h expected ff", button_out); end
        send_ps2(8'h00, 8'h00, 8'h75, 40'h0000000100);
        tick(3);
        checks++; if (button_out !== 8'hFF) begin failures++; $display("FAIL ps2_make_upper_nonzero: got %h expected ff", button_out); end
        send_ps2(8'h00, 8'h00, 8'h29, 40'd0);
        tick(2);
        checks++; if (button_out !== 8'hBF) begin failures++; $display("FAIL ps2_fire_029: got %h expected bf", button_out); end
        send_ps2(8'h00, 8'hF0, 8'h14, 40'd0);
        tick(2);
        checks++; if (button_out !== 8'hFF) begin failures++; $display("FAIL ps2_fire_014_break: got %h expected ff", button_out); end
        send_ps2(8'h00, 8'hE0, 8'h6B, 40'd0);
        tick(2);
        checks++; if (button_out !== 8'hFB) begin failures++; $display("FAIL ps2_left_ext: got %h expected fb", button_out); end
        send_ps2(8'hE0, 8'hF0, 8'h6B, 40'd0);
        tick(2);
        checks++; if (button_out !== 8'hFF) begin failures++; $display("FAIL ps2_left_release: got %h expected ff", button_out); end
        send_ps2(8'h00, 8'h00, 8'h1C, 40'd0);
        tick(2);
        checks++; if (button_out !== 8'hFF) begin failures++; $display("FAIL ps2_unmapped: got %h expected ff", button_out); end
        send_ps2(8'h00, 8'hE0, 8'h05, 40'd0);
        tick(3);
        checks++; if (seq_busy !== 1'b0) begin failures++; $display("FAIL ps2_ext_start_ignored: got busy %b expected 0", seq_busy); end
        $display("test_ps2 done: button_out=%h", button_out);
    endtask

    task automatic test_ps2_start;
        send_ps2(8'h00, 8'h00, 8'h05, 40'd0);
        tick(1);
        checks++; if (button_out !== 8'hFF) begin failures++; $display("FAIL ps2_start_1clk: got %h expected ff", button_out); end
        tick(1);
        checks++; if (button_out !== 8'hDF) begin failures++; $display("FAIL ps2_start_coin_2clk: got %h expected df", button_out); end
        send_ps2(8'h00, 8'hF0, 8'h05, 40'd0);
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(1);
        $display("test_ps2_start done: button_out=%h", button_out);
    endtask

    task automatic test_rotate;
        rotate = 1'b1;
        joy0 = 16'h0008;
        tick(1);
        checks++; if (button_out !== 8'hF7) begin failures++; $display("FAIL rotate_up_to_right: got %h expected f7", button_out); end
        rotate = 1'b0;
        tick(1);
        checks++; if (button_out !== 8'hFE) begin failures++; $display("FAIL norotate_up: got %h expected fe", button_out); end
        rotate = 1'b1;
        joy0 = 16'h0000;
        joy1 = 16'h0001;
        tick(1);
        checks++; if (button_out !== 8'hFD) begin failures++; $display("FAIL rotate_joy1_right_to_down: got %h expected fd", button_out); end
        joy1 = 16'h0000;
        rotate = 1'b0;
        tick(1);
        checks++; if (button_out !== 8'hFF) begin failures++; $display("FAIL rotate_clear: got %h expected ff", button_out); end
        $display("test_rotate done: button_out=%h", button_out);
    endtask

    task automatic test_auto_coin;
        int c, g, s, s2, fc;
        joy0 = 16'h0020;
        observe(120, 1'b0, 1'b0, c, g, s, s2, fc);
        checks++; if (fc !== 0) begin failures++; $display("FAIL coin_latency: got sample %0d expected 0", fc); end
        checks++; if (c !== 4) begin failures++; $display("FAIL coin_len: got %0d ce expected 4", c); end
        checks++; if (g !== 2) begin failures++; $display("FAIL gap_len: got %0d ce expected 2", g); end
        checks++; if (button_out !== 8'hEF) begin failures++; $display("FAIL start_held: got %h expected ef", button_out); end
        checks++; if (seq_busy !== 1'b1) begin failures++; $display("FAIL busy_held: got %b expected 1", seq_busy); end
        joy0 = 16'h0000;
        tick(1);
        checks++; if (seq_busy !== 1'b0) begin failures++; $display("FAIL busy_release: got %b expected 0", seq_busy); end
        checks++; if (button_out !== 8'hFF) begin failures++; $display("FAIL out_release: got %h expected ff", button_out); end
        $display("test_auto_coin done: coin=%0d gap=%0d", c, g);
    endtask

    task automatic test_early_release;
        int c, g, s, s2, fc;
        joy0 = 16'h0020;
        observe(120, 1'b1, 1'b0, c, g, s, s2, fc);
        checks++; if (c !== 4) begin failures++; $display("FAIL early_coin_len: got %0d ce expected 4", c); end
        checks++; if (g !== 2) begin failures++; $display("FAIL early_gap_len: got %0d ce expected 2", g); end
        checks++; if (s !== 3) begin failures++; $display("FAIL early_start_len: got %0d ce expected 3", s); end
        checks++; if (seq_busy !== 1'b0) begin failures++; $display("FAIL early_busy_end: got %b expected 0", seq_busy); end
        $display("test_early_release done: coin=%0d gap=%0d start=%0d", c, g, s);
    endtask

    task automatic test_simultaneous;
        int c, g, s, s2, fc;
        joy0 = 16'h0060;
        observe(120, 1'b1, 1'b1, c, g, s, s2, fc);
        checks++; if (s2 !== 0) begin failures++; $display("FAIL simul_start2_seen: got %0d low samples expected 0", s2); end
        checks++; if (s !== 3) begin failures++; $display("FAIL simul_start1_len: got %0d ce expected 3", s); end
        checks++; if (seq_busy !== 1'b1) begin failures++; $display("FAIL simul_hold_busy: got %b expected 1", seq_busy); end
        checks++; if (button_out !== 8'hFF) begin failures++; $display("FAIL simul_hold_out: got %h expected ff", button_out); end
        joy0 = 16'h0000;
        tick(3);
        checks++; if (seq_busy !== 1'b0) begin failures++; $display("FAIL simul_idle: got %b expected 0", seq_busy); end
        $display("test_simultaneous done: start=%0d start2_low=%0d", s, s2);
    endtask

    task automatic test_reset_mid;
        joy0 = 16'h0020;
        tick(2);
        checks++; if (button_out !== 8'hDF) begin failures++; $display("FAIL mid_coin: got %h expected df", button_out); end
        joy0 = 16'h0000;
        reset_n = 1'b0;
        tick(1);
        checks++; if (button_out !== 8'hFF) begin failures++; $display("FAIL mid_reset_out: got %h expected ff", button_out); end
        checks++; if (seq_busy !== 1'b0) begin failures++; $display("FAIL mid_reset_busy: got %b expected 0", seq_busy); end
        reset_n = 1'b1;
        tick(30);
        checks++; if (button_out !== 8'hFF) begin failures++; $display("FAIL mid_after_reset: got %h expected ff", button_out); end
        $display("test_reset_mid done: button_out=%h seq_busy=%b", button_out, seq_busy);
    endtask

    initial begin
        test_reset();
        test_ps2();
        test_ps2_start();
        test_rotate();
        test_auto_coin();
        test_early_release();
        test_simultaneous();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
